// File: rtl/fft_pkg.sv
// Shared constants and write-FSM state encoding for the FFT power capture block.
package fft_pkg;

    localparam int unsigned FFT_DATA_W = 25;
    localparam int unsigned FFT_N_PTS  = 512;
    localparam int unsigned FFT_ADDR_W = $clog2(FFT_N_PTS);
    localparam int unsigned FFT_PWR_W  = 32;
    localparam int unsigned FFT_SHIFT  = 18;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StCommit
    } cap_state_e;

endpackage

// File: rtl/power_pipe.sv
// Three-stage |x|^2 pipeline: square, sum, shift-and-saturate, with valid/sop/bin sideband.
module power_pipe #(
    parameter int unsigned DATA_W = 25,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned PWR_W  = 32,
    parameter int unsigned SHIFT  = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    input  logic                     i_sop,
    input  logic [ADDR_W-1:0]        i_bin,
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    output logic                     o_valid,
    output logic                     o_sop,
    output logic [ADDR_W-1:0]        o_bin,
    output logic [PWR_W-1:0]         o_pwr,
    output logic                     o_busy
);

    localparam int unsigned SQ_W  = 2 * DATA_W;
    localparam int unsigned SUM_W = SQ_W + 1;

    logic signed [SQ_W-1:0] w_re_ext;
    logic signed [SQ_W-1:0] w_im_ext;
    logic [SQ_W-1:0]        r_sq_re;
    logic [SQ_W-1:0]        r_sq_im;
    logic [SUM_W-1:0]       r_sum;
    logic [SUM_W-1:0]       w_shifted;
    logic                   w_sat;
    logic [PWR_W-1:0]       r_pwr;
    logic [2:0]             r_vld;
    logic [2:0]             r_sop;
    logic [ADDR_W-1:0]      r_bin [3];

    assign w_re_ext  = {{DATA_W{i_re[DATA_W-1]}}, i_re};
    assign w_im_ext  = {{DATA_W{i_im[DATA_W-1]}}, i_im};
    assign w_shifted = r_sum >> SHIFT;
    // Anything left above PWR_W after the shift clamps to full scale.
    assign w_sat     = |w_shifted[SUM_W-1:PWR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[1:0], i_valid};
        end
    end

    always_ff @(posedge clk) begin
        r_sq_re  <= w_re_ext * w_re_ext;
        r_sq_im  <= w_im_ext * w_im_ext;
        r_sum    <= {1'b0, r_sq_re} + {1'b0, r_sq_im};
        r_pwr    <= w_sat ? '1 : w_shifted[PWR_W-1:0];
        r_sop    <= {r_sop[1:0], i_sop};
        r_bin[0] <= i_bin;
        r_bin[1] <= r_bin[0];
        r_bin[2] <= r_bin[1];
    end

    assign o_valid = r_vld[2];
    assign o_sop   = r_sop[2];
    assign o_bin   = r_bin[2];
    assign o_pwr   = r_pwr;
    assign o_busy  = |r_vld;

endmodule

// File: rtl/fft_power_capture.sv
// Captures one FFT frame of per-bin power into a double-buffered bin memory and tracks the
// peak bin; the reader releases each completed bank with frame_ack.
module fft_power_capture
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = FFT_DATA_W,
    parameter int unsigned N_PTS  = FFT_N_PTS,
    parameter int unsigned ADDR_W = FFT_ADDR_W,
    parameter int unsigned PWR_W  = FFT_PWR_W,
    parameter int unsigned SHIFT  = FFT_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic                     src_sop,
    input  logic                     src_eop,
    input  logic signed [DATA_W-1:0] src_real,
    input  logic signed [DATA_W-1:0] src_imag,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [PWR_W-1:0]         rd_data,
    output logic                     frame_ready,
    input  logic                     frame_ack,
    output logic [ADDR_W-1:0]        peak_bin,
    output logic [PWR_W-1:0]         peak_pwr,
    output logic [15:0]              frame_count,
    output logic [15:0]              drop_count
);

    cap_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_bin, w_bin_nxt, w_bin_idx;
    logic              w_accept, w_push, w_drop, w_commit, w_swap_in;
    logic              r_wr_bank, r_rd_valid, r_pend, r_rd_en, r_rd_sel;
    logic [ADDR_W-1:0] r_run_bin, r_pend_bin, r_peak_bin;
    logic [PWR_W-1:0]  r_run_pwr, r_pend_pwr, r_peak_pwr;
    logic [15:0]       r_frame_cnt, r_drop_cnt;
    logic              w_pp_valid, w_pp_sop, w_pp_busy;
    logic [ADDR_W-1:0] w_pp_bin;
    logic [PWR_W-1:0]  w_pp_pwr;
    logic [PWR_W-1:0]  r_mem0 [N_PTS];
    logic [PWR_W-1:0]  r_mem1 [N_PTS];
    logic [PWR_W-1:0]  r_q0, r_q1;

    // r_pend means the write bank holds a finished frame behind the held read bank.
    assign src_ready = !reset && (r_state != StCommit) && !(r_state == StIdle && r_pend);
    assign w_accept  = src_valid && src_ready;
    assign w_bin_idx = src_sop ? '0 : r_bin;
    assign w_swap_in = r_pend && !r_rd_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept && src_sop) begin
                    w_push      = 1'b1;
                    w_bin_nxt   = ADDR_W'(1);
                    w_state_nxt = StCapture;
                end
            end
            StCapture: begin
                if (w_accept) begin
                    w_push    = 1'b1;
                    w_bin_nxt = w_bin_idx + ADDR_W'(1);
                    w_drop    = src_sop;
                end
            end
            StCommit: begin
                if (!w_pp_busy) begin
                    w_commit    = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (w_push && src_eop) begin
            if (w_bin_idx == ADDR_W'(N_PTS - 1)) begin
                w_state_nxt = StCommit;
            end else begin
                w_drop      = 1'b1;
                w_state_nxt = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_bin   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bin   <= w_bin_nxt;
        end
    end

    power_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PWR_W  (PWR_W),
        .SHIFT  (SHIFT)
    ) u_power_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_push),
        .i_sop   (src_sop),
        .i_bin   (w_bin_idx),
        .i_re    (src_real),
        .i_im    (src_imag),
        .o_valid (w_pp_valid),
        .o_sop   (w_pp_sop),
        .o_bin   (w_pp_bin),
        .o_pwr   (w_pp_pwr),
        .o_busy  (w_pp_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_pend      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_run_bin   <= '0;
            r_run_pwr   <= '0;
            r_pend_bin  <= '0;
            r_pend_pwr  <= '0;
            r_peak_bin  <= '0;
            r_peak_pwr  <= '0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_rd_en  <= r_rd_valid;
            r_rd_sel <= ~r_wr_bank;
            if (w_pp_valid && (w_pp_sop || w_pp_pwr > r_run_pwr)) begin
                r_run_bin <= w_pp_bin;
                r_run_pwr <= w_pp_pwr;
            end
            if (frame_ack && r_rd_valid) begin
                r_rd_valid <= 1'b0;
            end
            if (w_commit) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
                if (!r_rd_valid) begin
                    r_wr_bank  <= ~r_wr_bank;
                    r_rd_valid <= 1'b1;
                    r_peak_bin <= r_run_bin;
                    r_peak_pwr <= r_run_pwr;
                end else begin
                    r_pend     <= 1'b1;
                    r_pend_bin <= r_run_bin;
                    r_pend_pwr <= r_run_pwr;
                end
            end else if (w_swap_in) begin
                r_wr_bank  <= ~r_wr_bank;
                r_rd_valid <= 1'b1;
                r_pend     <= 1'b0;
                r_peak_bin <= r_pend_bin;
                r_peak_pwr <= r_pend_pwr;
            end
            if (w_drop && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_pp_valid && !r_wr_bank) begin
            r_mem0[w_pp_bin] <= w_pp_pwr;
        end
        r_q0 <= r_mem0[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (w_pp_valid && r_wr_bank) begin
            r_mem1[w_pp_bin] <= w_pp_pwr;
        end
        r_q1 <= r_mem1[rd_addr];
    end

    assign rd_data     = r_rd_en ? (r_rd_sel ? r_q1 : r_q0) : '0;
    assign frame_ready = r_rd_valid;
    assign peak_bin    = r_peak_bin;
    assign peak_pwr    = r_peak_pwr;
    assign frame_count = r_frame_cnt;
    assign drop_count  = r_drop_cnt;

endmodule
